// File: rtl/key_conditioner.sv
// Two-key debouncer: per-key 2-flop synchronizer, debounce FSM, press strobe and held level.
// Optional macro KEY_TIE_BLOCK_EN drops both strobes in any cycle where both keys fire together.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_l_raw,
  input  logic       key_r_raw,
  output logic       l_pulse,
  output logic       r_pulse,
  output logic       l_held,
  output logic       r_held,
  output logic [1:0] l_state,
  output logic [1:0] r_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } key_state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the left key, index 1 the right key.
  logic [1:0] raw;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] fire;
  logic       l_next;
  logic       r_next;
  key_state_t state      [2];
  key_state_t state_next [2];
  logic [7:0] cnt        [2];
  logic [7:0] cnt_next   [2];

  assign raw = {key_r_raw, key_l_raw};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 2'b00;
      s2      <= 2'b00;
      l_pulse <= 1'b0;
      r_pulse <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        state[k] <= IDLE;
        cnt[k]   <= 8'd0;
      end
    end else begin
      s1      <= raw;
      s2      <= s1;
      l_pulse <= l_next;
      r_pulse <= r_next;
      for (int k = 0; k < 2; k++) begin
        state[k] <= state_next[k];
        cnt[k]   <= cnt_next[k];
      end
    end
  end

  // cnt only advances while below CNT_LAST, so it never wraps.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_next[k] = state[k];
      cnt_next[k]   = cnt[k];
      fire[k]       = 1'b0;
      case (state[k])
        IDLE: begin
          if (s2[k]) begin
            state_next[k] = PRESS_WAIT;
            cnt_next[k]   = 8'd0;
          end
        end
        PRESS_WAIT: begin
          if (!s2[k]) begin
            state_next[k] = IDLE;
          end else if (cnt[k] == CNT_LAST) begin
            state_next[k] = HELD;
            fire[k]       = 1'b1;
          end else begin
            cnt_next[k] = cnt[k] + 8'd1;
          end
        end
        HELD: begin
          if (!s2[k]) begin
            state_next[k] = REL_WAIT;
            cnt_next[k]   = 8'd0;
          end
        end
        REL_WAIT: begin
          if (s2[k]) begin
            state_next[k] = HELD;
          end else if (cnt[k] == CNT_LAST) begin
            state_next[k] = IDLE;
          end else begin
            cnt_next[k] = cnt[k] + 8'd1;
          end
        end
        default: begin
          state_next[k] = IDLE;
          cnt_next[k]   = 8'd0;
        end
      endcase
    end
  end

`ifdef KEY_TIE_BLOCK_EN
  // A simultaneous press is ambiguous to the light chain, so neither strobe is sent.
  assign l_next = fire[0] & ~fire[1];
  assign r_next = fire[1] & ~fire[0];
`else
  assign l_next = fire[0];
  assign r_next = fire[1];
`endif

  assign l_held  = (state[0] == HELD) || (state[0] == REL_WAIT);
  assign r_held  = (state[1] == HELD) || (state[1] == REL_WAIT);
  assign l_state = state[0];
  assign r_state = state[1];

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the stable-input cycles required before a press or release is accepted; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous, active-high; clock is clk.
REQ-004 SHALL have port key_l_raw, input, 1, left key raw level, asynchronous, 1 = pressed (polarity already inverted at top level).
REQ-005 SHALL have port key_r_raw, input, 1, right key raw level, same rules as key_l_raw.
REQ-006 SHALL have port l_pulse, output, 1, single-cycle strobe per accepted left press; feeds the L input of the light chain.
REQ-007 SHALL have port r_pulse, output, 1, single-cycle strobe per accepted right press; feeds the R input of the light chain.
REQ-008 SHALL have port l_held, output, 1, debounced left level.
REQ-009 SHALL have port r_held, output, 1, debounced right level.

Function
REQ-010 SHALL pass each raw key through its own two-flop synchronizer (s1, s2); downstream logic uses s2 only.
REQ-011 SHALL implement one independent per-key FSM with states IDLE, PRESS_WAIT, HELD, REL_WAIT and an 8-bit counter cnt.
REQ-012 SHALL, in IDLE with s2=1, go to PRESS_WAIT with cnt=0; otherwise stay in IDLE.
REQ-013 SHALL, in PRESS_WAIT: if s2=0 return to IDLE; else if cnt==DEBOUNCE_CYCLES-1 go to HELD; else increment cnt.
REQ-014 SHALL, in HELD with s2=0, go to REL_WAIT with cnt=0; otherwise stay in HELD.
REQ-015 SHALL, in REL_WAIT: if s2=1 return to HELD with no new pulse; else if cnt==DEBOUNCE_CYCLES-1 go to IDLE; else increment cnt.
REQ-016 SHALL register the pulse output high for exactly the one cycle following each PRESS_WAIT->HELD transition, and low at all other times.
REQ-017 SHALL drive held high whenever the state is HELD or REL_WAIT.
REQ-018 SHALL assert the pulse on rising edge k+DEBOUNCE_CYCLES+2 when raw is high and stable from before edge k, where edge k is the first edge at which s1 samples 1.
REQ-019 SHALL produce no pulse for a raw high lasting fewer than DEBOUNCE_CYCLES+1 cycles.
REQ-020 SHALL produce at most one pulse per continuous hold, regardless of hold length or of release glitches shorter than DEBOUNCE_CYCLES.
REQ-021 SHALL never increment cnt past DEBOUNCE_CYCLES-1, so cnt cannot wrap.
REQ-022 SHALL keep the two key channels fully independent except as stated in REQ-027.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, clear s1, s2 and cnt to 0, force both FSMs to IDLE, and drive l_pulse, r_pulse, l_held and r_held to 0 on the next cycle.
REQ-024 SHALL abort any in-progress debounce when reset is asserted mid-operation; no pulse is emitted for that press.
REQ-025 SHALL, for a key held continuously through reset release, emit exactly one pulse with the latency of REQ-018, measured from the first post-reset edge.

Configuration
REQ-026 SHALL support macro KEY_TIE_BLOCK_EN.
REQ-027 SHALL, when KEY_TIE_BLOCK_EN is defined, suppress both l_pulse and r_pulse in any cycle where both would assert; FSM states and held outputs are unaffected.
REQ-028 SHALL, when KEY_TIE_BLOCK_EN is undefined, assert both pulses in the same cycle.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 SHALL cover: reset for 2 cycles -> all outputs 0; key_l_raw=1 from edge 10 for 20 cycles -> l_pulse=1 only after edge 16; l_held=1 from edge 16 until 4 debounce cycles after release.
REQ-030 SHALL cover: key_r_raw high for 3 cycles, then low -> r_pulse never asserts; r_held stays 0.
REQ-031 SHALL cover: left held 30 cycles with a 2-cycle low glitch mid-hold -> exactly one l_pulse; l_held never drops.
REQ-032 SHALL cover: both keys raised at the same edge and held -> same-cycle pulses with the macro undefined; no pulses with KEY_TIE_BLOCK_EN defined.
REQ-033 SHALL cover: reset asserted 2 cycles into PRESS_WAIT while the key stays high -> no pulse during reset; exactly one pulse 6 edges after reset deasserts.
REQ-034 SHALL cover: three press/release cycles of 8 high and 8 low -> exactly three l_pulse strobes, each one cycle wide.
